// File: rtl/stream_dma_engine.sv
// stream_dma_engine: Wishbone-programmed DMA feeding an AXI-Stream engine.
// Define STREAM_DMA_IRQ_EN to add irq_o with CTRL[3] as irq enable.
module stream_dma_engine #(
  parameter int          DW         = 32,
  parameter int          FIFO_DEPTH = 8,
  parameter int          LEN_W      = 16,
  parameter logic [31:0] BASE       = 32'h3000_0000
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic [DW-1:0] wbs_dat_i,
  output logic          wbs_ack_o,
  output logic [DW-1:0] wbs_dat_o,
  output logic          dma_stb_i,
  output logic          dma_cyc_i,
  output logic          dma_we_i,
  output logic [3:0]    dma_sel_i,
  output logic [31:0]   dma_adr_i,
  output logic [DW-1:0] dma_dat_i,
  input  logic          dma_ack_o,
  input  logic [DW-1:0] dma_dat_o,
  output logic          ss_tvalid,
  output logic [DW-1:0] ss_tdata,
  input  logic          ss_tready,
  input  logic          sm_tvalid,
  input  logic [DW-1:0] sm_tdata,
  output logic          sm_tready
`ifdef STREAM_DMA_IRQ_EN
  ,
  output logic          irq_o
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_RD, S_WR} state_t;

  state_t           r_state, w_next;
  logic             r_ack;
  logic [DW-1:0]    r_rdata;
  logic [31:0]      r_src, r_dst;
  logic [LEN_W-1:0] r_len, r_rd_cnt, r_wr_cnt;
  logic             r_busy, r_done, r_ien;
  logic             w_hit, w_req, w_wr, w_start, w_finish;
  logic [1:0]       w_off;
  logic [DW-1:0]    w_rd_mux;

  logic [DW-1:0] r_in_mem [FIFO_DEPTH];
  logic [AW-1:0] r_in_wp, r_in_rp;
  logic [AW:0]   r_in_cnt;
  logic          w_in_push, w_in_pop, w_in_full;
  logic [DW-1:0] r_out_mem [FIFO_DEPTH];
  logic [AW-1:0] r_out_wp, r_out_rp;
  logic [AW:0]   r_out_cnt;
  logic          w_out_push, w_out_pop, w_out_empty;

  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, wbs_sel_i, wbs_adr_i[1:0]};

  // Slave decode: one request per ack, ack is a registered single pulse
  assign w_hit   = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE[31:4]);
  assign w_req   = w_hit & ~r_ack;
  assign w_wr    = w_req & wbs_we_i;
  assign w_off   = wbs_adr_i[3:2];
  assign w_start = w_wr & (w_off == 2'd0) & wbs_dat_i[0] & ~r_busy;

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_rdata;

  // Register read mux
  always_comb begin
    w_rd_mux = '0;
    case (w_off)
      2'd0:    w_rd_mux = DW'({r_ien, r_busy, r_done, 1'b0});
      2'd1:    w_rd_mux = DW'(r_src);
      2'd2:    w_rd_mux = DW'(r_dst);
      default: w_rd_mux = DW'(r_len);
    endcase
  end

  // Slave registers, start/done/busy control
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ien   <= 1'b0;
    end else begin
      r_ack <= w_req;
      if (w_req && !wbs_we_i) r_rdata <= w_rd_mux;
      if (w_wr && !r_busy) begin
        case (w_off)
          2'd1:    r_src <= 32'(wbs_dat_i);
          2'd2:    r_dst <= 32'(wbs_dat_i);
          2'd3:    r_len <= wbs_dat_i[LEN_W-1:0];
          default: ;
        endcase
      end
      if (w_wr && w_off == 2'd0) begin
`ifdef STREAM_DMA_IRQ_EN
        r_ien <= wbs_dat_i[3];
`endif
        if (wbs_dat_i[1]) r_done <= 1'b0;
        if (w_start) begin
          if (r_len == '0) begin
            r_done <= 1'b1;
          end else begin
            r_busy <= 1'b1;
            r_done <= 1'b0;
          end
        end
      end
      if (w_finish) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

`ifdef STREAM_DMA_IRQ_EN
  logic r_irq;
  // Interrupt level follows enabled done, one cycle later
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_irq <= 1'b0;
    else          r_irq <= r_ien & r_done;
  end
  assign irq_o = r_irq;
`endif

  // FSM state and transfer counters
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state  <= S_IDLE;
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_rd_cnt <= '0;
        r_wr_cnt <= '0;
      end else begin
        if (w_in_push) r_rd_cnt <= r_rd_cnt + LEN_W'(1);
        if (w_out_pop) r_wr_cnt <= r_wr_cnt + LEN_W'(1);
      end
    end
  end

  // Arbitration and master bus drive; writes win to drain results
  always_comb begin
    w_next    = r_state;
    w_finish  = 1'b0;
    w_in_push = 1'b0;
    w_out_pop = 1'b0;
    dma_stb_i = 1'b0;
    dma_cyc_i = 1'b0;
    dma_we_i  = 1'b0;
    dma_adr_i = '0;
    dma_dat_i = '0;
    case (r_state)
      S_IDLE: if (r_busy) w_next = S_ARB;
      S_ARB: begin
        if (r_wr_cnt == r_len) begin
          w_finish = 1'b1;
          w_next   = S_IDLE;
        end else if (!w_out_empty && r_wr_cnt < r_len) begin
          w_next = S_WR;
        end else if (!w_in_full && r_rd_cnt < r_len) begin
          w_next = S_RD;
        end
      end
      S_RD: begin
        dma_stb_i = 1'b1;
        dma_cyc_i = 1'b1;
        dma_adr_i = r_src + 32'({r_rd_cnt, 2'b00});
        if (dma_ack_o) begin
          w_in_push = 1'b1;
          w_next    = S_ARB;
        end
      end
      default: begin
        dma_stb_i = 1'b1;
        dma_cyc_i = 1'b1;
        dma_we_i  = 1'b1;
        dma_adr_i = r_dst + 32'({r_wr_cnt, 2'b00});
        dma_dat_i = r_out_mem[r_out_rp];
        if (dma_ack_o) begin
          w_out_pop = 1'b1;
          w_next    = S_ARB;
        end
      end
    endcase
  end

  assign dma_sel_i = 4'hF;

  assign w_in_full   = (r_in_cnt == FULL_C);
  assign ss_tvalid   = (r_in_cnt != '0);
  assign ss_tdata    = r_in_mem[r_in_rp];
  assign w_in_pop    = ss_tvalid & ss_tready;
  assign w_out_empty = (r_out_cnt == '0);
  assign sm_tready   = (r_out_cnt != FULL_C);
  assign w_out_push  = sm_tvalid & sm_tready;

  // FIFO storage
  always_ff @(posedge wb_clk_i) begin
    if (w_in_push)  r_in_mem[r_in_wp]   <= dma_dat_o;
    if (w_out_push) r_out_mem[r_out_wp] <= sm_tdata;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_in_wp   <= '0;
      r_in_rp   <= '0;
      r_in_cnt  <= '0;
      r_out_wp  <= '0;
      r_out_rp  <= '0;
      r_out_cnt <= '0;
    end else begin
      if (w_in_push)  r_in_wp  <= r_in_wp + AW'(1);
      if (w_in_pop)   r_in_rp  <= r_in_rp + AW'(1);
      if (w_out_push) r_out_wp <= r_out_wp + AW'(1);
      if (w_out_pop)  r_out_rp <= r_out_rp + AW'(1);
      case ({w_in_push, w_in_pop})
        2'b10:   r_in_cnt <= r_in_cnt + (AW+1)'(1);
        2'b01:   r_in_cnt <= r_in_cnt - (AW+1)'(1);
        default: ;
      endcase
      case ({w_out_push, w_out_pop})
        2'b10:   r_out_cnt <= r_out_cnt + (AW+1)'(1);
        2'b01:   r_out_cnt <= r_out_cnt - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_dma_engine.sv
// tb_stream_dma_engine: scoreboard bench with arbiter memory and x+1 engine.
// Expected write data is queued as source words are generated.
module tb_stream_dma_engine;

  localparam logic [31:0] A_CTRL = 32'h3000_0000;
  localparam logic [31:0] A_SRC  = 32'h3000_0004;
  localparam logic [31:0] A_DST  = 32'h3000_0008;
  localparam logic [31:0] A_LEN  = 32'h3000_000C;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'hF;
  logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        dma_stb_i, dma_cyc_i, dma_we_i;
  logic [3:0]  dma_sel_i;
  logic [31:0] dma_adr_i, dma_dat_i;
  logic        dma_ack_o = 1'b0;
  logic [31:0] dma_dat_o = '0;
  logic        ss_tvalid;
  logic [31:0] ss_tdata;
  logic        ss_tready = 1'b0;
  logic        sm_tvalid = 1'b0;
  logic [31:0] sm_tdata = '0;
  logic        sm_tready;
`ifdef STREAM_DMA_IRQ_EN
  logic        irq_o;
`endif

  stream_dma_engine dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i),
    .wbs_we_i(wbs_we_i), .wbs_sel_i(wbs_sel_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .dma_stb_i(dma_stb_i), .dma_cyc_i(dma_cyc_i),
    .dma_we_i(dma_we_i), .dma_sel_i(dma_sel_i),
    .dma_adr_i(dma_adr_i), .dma_dat_i(dma_dat_i),
    .dma_ack_o(dma_ack_o), .dma_dat_o(dma_dat_o),
    .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata),
    .ss_tready(ss_tready),
    .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata),
    .sm_tready(sm_tready)
`ifdef STREAM_DMA_IRQ_EN
    , .irq_o(irq_o)
`endif
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int errors = 0;
  int checks = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] eng_q [$];
  logic [31:0] exp_q [$];
  logic [31:0] src_b = '0, dst_b = '0;
  int rd_n = 0, wr_n = 0, ack_dly = 0, stb_cnt = 0;
  logic ss_rdy = 1'b1, sm_en = 1'b1, saw_full = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Arbiter model: acks after ack_dly idle cycles, checks every access
  initial begin : arb
    int dly;
    dly = 0;
    forever begin
      @(negedge wb_clk_i);
      dma_ack_o = 1'b0;
      if (dma_stb_i) stb_cnt++;
      if (!dma_stb_i || !dma_cyc_i || wb_rst_i) begin
        dly = 0;
      end else if (dly < ack_dly) begin
        dly++;
      end else begin
        dly = 0;
        dma_ack_o = 1'b1;
        chk("dma_sel", 32'(dma_sel_i), 32'hF);
        if (dma_we_i) begin
          chk("wr_adr", dma_adr_i, dst_b + 32'(4 * wr_n));
          if (exp_q.size() == 0) chk("wr_extra", 32'd1, 32'd0);
          else chk("wr_dat", dma_dat_i, exp_q.pop_front());
          mem[dma_adr_i] = dma_dat_i;
          wr_n++;
        end else begin
          chk("rd_adr", dma_adr_i, src_b + 32'(4 * rd_n));
          dma_dat_o = mem.exists(dma_adr_i) ? mem[dma_adr_i] : '0;
          rd_n++;
        end
      end
    end
  end

  // Engine model: returns x+1 for every accepted input word
  initial begin : eng
    forever begin
      @(negedge wb_clk_i);
      ss_tready = ss_rdy;
      if (!sm_tready) saw_full = 1'b1;
      if (sm_en && !wb_rst_i && eng_q.size() > 0) begin
        sm_tvalid = 1'b1;
        sm_tdata  = eng_q[0];
      end else begin
        sm_tvalid = 1'b0;
        sm_tdata  = '0;
      end
      if (sm_tvalid && sm_tready) void'(eng_q.pop_front());
      if (ss_tvalid && ss_tready) eng_q.push_back(ss_tdata + 32'd1);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] q);
    int n;
    @(negedge wb_clk_i);
    wbs_adr_i = a; wbs_dat_i = d; wbs_we_i = we;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
    n = 0;
    do begin
      @(posedge wb_clk_i); #1; n++;
    end while (!wbs_ack_o && n < 8);
    if (!wbs_ack_o) chk("wb_ack_timeout", 32'd0, 32'd1);
    q = wbs_dat_o;
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] q;
    wb_xfer(1'b1, a, d, q);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] q);
    wb_xfer(1'b0, a, '0, q);
  endtask

  task automatic run_xfer(input logic [31:0] s, input logic [31:0] d,
                          input int len);
    logic [31:0] w;
    src_b = s; dst_b = d; rd_n = 0; wr_n = 0;
    for (int i = 0; i < len; i++) begin
      w = $urandom;
      mem[s + 32'(4 * i)] = w;
      exp_q.push_back(w + 32'd1);
    end
    wb_write(A_SRC, s);
    wb_write(A_DST, d);
    wb_write(A_LEN, 32'(len));
    wb_write(A_CTRL, 32'h1);
  endtask

  task automatic wait_done(input string tag);
    logic [31:0] v;
    int n;
    n = 0; v = '0;
    while (n < 200) begin
      wb_read(A_CTRL, v);
      if (v[1]) break;
      n++;
    end
    chk(tag, v & 32'h6, 32'h2);
  endtask

  initial begin : main
    logic [31:0] v;
    logic acc;
    int n, s0;

    cyc(3);
    chk("rst_wbs_ack", 32'(wbs_ack_o), 32'd0);
    chk("rst_dma_stb", 32'(dma_stb_i), 32'd0);
    chk("rst_ss_tvalid", 32'(ss_tvalid), 32'd0);
    chk("rst_sm_tready", 32'(sm_tready), 32'd1);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    wb_read(A_CTRL, v);
    chk("rst_ctrl", v, 32'd0);

    @(negedge wb_clk_i);
    wbs_adr_i = 32'h3000_0010; wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
    acc = 1'b0;
    repeat (3) begin @(posedge wb_clk_i); #1; acc |= wbs_ack_o; end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    chk("nohit_ack", 32'(acc), 32'd0);

    run_xfer(32'h3800_0000, 32'h3800_0100, 4);
    wait_done("t2_done");
    chk("t2_wr_n", 32'(wr_n), 32'd4);
    chk("t2_exp_empty", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 4; i++)
      chk("t2_dst_mem", mem[32'h3800_0100 + 32'(4 * i)],
          mem[32'h3800_0000 + 32'(4 * i)] + 32'd1);
    wb_write(A_CTRL, 32'h2);
    wb_read(A_CTRL, v);
    chk("w1c_done", v, 32'd0);

    ss_rdy = 1'b0;
    run_xfer(32'h3800_0200, 32'h3800_0300, 16);
    cyc(60);
    chk("t3_stall_reads", 32'(rd_n), 32'd8);
    chk("t3_stb_idle", 32'(dma_stb_i), 32'd0);
    wb_read(A_CTRL, v);
    chk("t3_busy", v, 32'h4);
    wb_write(A_LEN, 32'd5);
    wb_write(A_SRC, 32'h1234_5670);
    wb_write(A_CTRL, 32'h1);
    cyc(10);
    chk("t5_restart_ign", 32'(rd_n), 32'd8);
    wb_read(A_LEN, v);
    chk("t5_len_locked", v, 32'd16);
    wb_read(A_SRC, v);
    chk("t5_src_locked", v, 32'h3800_0200);
    ss_rdy = 1'b1;
    wait_done("t3_done");
    chk("t3_rd_n", 32'(rd_n), 32'd16);
    chk("t3_wr_n", 32'(wr_n), 32'd16);

    sm_en = 1'b0;
    saw_full = 1'b0;
    run_xfer(32'h3800_0400, 32'h3800_0500, 16);
    n = 0;
    while (rd_n < 16 && n < 300) begin cyc(1); n++; end
    chk("t4_all_read", 32'(rd_n), 32'd16);
    ack_dly = 5;
    sm_en = 1'b1;
    wait_done("t4_done");
    chk("t4_saw_full", 32'(saw_full), 32'd1);
    chk("t4_wr_n", 32'(wr_n), 32'd16);
    chk("t4_exp_empty", 32'(exp_q.size()), 32'd0);

    ack_dly = 0;
    s0 = stb_cnt;
    wb_write(A_LEN, 32'd0);
    wb_write(A_CTRL, 32'h1);
    wb_read(A_CTRL, v);
    chk("t5_len0_done", v, 32'h2);
    cyc(5);
    chk("t5_len0_nobus", 32'(stb_cnt - s0), 32'd0);

    ack_dly = 5;
    run_xfer(32'h3800_0600, 32'h3800_0700, 4);
    n = 0;
    @(negedge wb_clk_i);
    while (!(dma_stb_i && dma_we_i) && n < 300) begin
      @(negedge wb_clk_i); n++;
    end
    chk("t6_saw_wr", 32'(dma_stb_i & dma_we_i), 32'd1);
    wb_rst_i = 1'b1;
    sm_en = 1'b0;
    @(posedge wb_clk_i); #1;
    chk("t6_stb_low", 32'(dma_stb_i), 32'd0);
    chk("t6_ss_tvalid", 32'(ss_tvalid), 32'd0);
    chk("t6_sm_tready", 32'(sm_tready), 32'd1);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    eng_q.delete();
    exp_q.delete();
    cyc(2);
    chk("t6_stb_stays", 32'(dma_stb_i), 32'd0);
    wb_read(A_CTRL, v);
    chk("t6_ctrl", v, 32'd0);
    wb_read(A_SRC, v);
    chk("t6_src", v, 32'd0);
    wb_read(A_LEN, v);
    chk("t6_len", v, 32'd0);
    sm_en = 1'b1;
    ack_dly = 0;
    run_xfer(32'h3800_0800, 32'h3800_0900, 4);
    wait_done("t6_post_done");
    chk("t6_post_wr_n", 32'(wr_n), 32'd4);
    chk("t6_post_exp", 32'(exp_q.size()), 32'd0);

`ifdef STREAM_DMA_IRQ_EN
    wb_write(A_LEN, 32'd0);
    wb_write(A_CTRL, 32'h9);
    cyc(2);
    chk("irq_set", 32'(irq_o), 32'd1);
    wb_write(A_CTRL, 32'hA);
    cyc(2);
    chk("irq_clr", 32'(irq_o), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
